// File: rtl/rx_ts_pkg.sv
// ---------------------------------------------------------------------------
// rx_ts_pkg: shared FSM state, stamp-field defaults and width checks for RX tagging.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rx_ts_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } rx_ts_state_t;

  // Shared with the DMA-side stamp extractor so both agree on the field.
  localparam int TS_TUSER_OFFSET_DEF = 32;
  localparam int TIMESTAMP_WIDTH_DEF = 64;

  function automatic bit ts_field_fits(input int offset, input int ts_width, input int tuser_width);
    return (offset >= 0) && (ts_width > 0) && (offset + ts_width <= tuser_width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_skid_slice.sv
// ---------------------------------------------------------------------------
// axis_skid_slice: 2-entry registered valid/ready slice, full throughput, registered ready.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axis_skid_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      s_ready    <= 1'b0;
    end else if (!m_valid || m_ready) begin
      // Output slot is free this cycle: drain the skid entry first to keep order.
      s_ready <= 1'b1;
      if (skid_valid) begin
        m_data     <= skid_data;
        m_valid    <= 1'b1;
        skid_valid <= 1'b0;
      end else if (s_valid && s_ready) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
      end else begin
        m_valid <= 1'b0;
      end
    end else if (s_valid && s_ready) begin
      skid_data  <= s_data;
      skid_valid <= 1'b1;
      s_ready    <= 1'b0;
    end else begin
      s_ready <= !skid_valid;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_timestamp_tagger.sv
// ---------------------------------------------------------------------------
// rx_timestamp_tagger: writes the arrival stamp into TUSER of each packet's first beat.
// Optional macro RX_TS_LATENCY_COMP_EN subtracts TS_COMP_TICKS from the stamp. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rx_timestamp_tagger
  import rx_ts_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int TIMESTAMP_WIDTH    = TIMESTAMP_WIDTH_DEF,
  parameter int TS_TUSER_OFFSET    = TS_TUSER_OFFSET_DEF,
  parameter int TS_COMP_TICKS      = 0
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  input  logic [TIMESTAMP_WIDTH-1:0]      stamp_counter,
  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [31:0]                     tagged_pkts
);

  localparam int STRB_WIDTH  = C_AXIS_DATA_WIDTH / 8;
  localparam int SLICE_WIDTH = C_AXIS_DATA_WIDTH + STRB_WIDTH + C_AXIS_TUSER_WIDTH + 1;

  if (!ts_field_fits(TS_TUSER_OFFSET, TIMESTAMP_WIDTH, C_AXIS_TUSER_WIDTH)) begin : g_ts_field_check
    $error("rx_timestamp_tagger: stamp field does not fit inside TUSER");
  end

  rx_ts_state_t                 state;
  logic [TIMESTAMP_WIDTH-1:0]   ts_hold;
  logic                         ts_held;
  logic [TIMESTAMP_WIDTH-1:0]   live_stamp;
  logic [TIMESTAMP_WIDTH-1:0]   insert_stamp;
  logic [C_AXIS_TUSER_WIDTH-1:0] tuser_tagged;
  logic [SLICE_WIDTH-1:0]       s_slice;
  logic [SLICE_WIDTH-1:0]       m_slice;
  logic                         s_hs;

`ifdef RX_TS_LATENCY_COMP_EN
  localparam logic [TIMESTAMP_WIDTH-1:0] COMP_TICKS = TIMESTAMP_WIDTH'(TS_COMP_TICKS);
  assign live_stamp = stamp_counter - COMP_TICKS;
`else
  logic unused_comp_ticks;
  assign unused_comp_ticks = (TS_COMP_TICKS != 0);
  assign live_stamp        = stamp_counter;
`endif

  // A first beat accepted on its first valid cycle has no held stamp yet.
  assign insert_stamp = ts_held ? ts_hold : live_stamp;
  assign s_hs         = s_axis_tvalid && s_axis_tready;

  always_comb begin
    tuser_tagged = s_axis_tuser;
    if (state == IDLE) begin
      tuser_tagged[TS_TUSER_OFFSET +: TIMESTAMP_WIDTH] = insert_stamp;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state       <= IDLE;
      ts_hold     <= '0;
      ts_held     <= 1'b0;
      tagged_pkts <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s_hs) begin
            tagged_pkts <= tagged_pkts + 32'd1;
            ts_held     <= 1'b0;
            state       <= s_axis_tlast ? IDLE : IN_PKT;
          end else if (s_axis_tvalid && !ts_held) begin
            ts_hold <= live_stamp;
            ts_held <= 1'b1;
          end
        end
        IN_PKT: begin
          if (s_hs && s_axis_tlast) begin
            state   <= IDLE;
            ts_held <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_slice = {s_axis_tdata, s_axis_tstrb, tuser_tagged, s_axis_tlast};
  assign {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast} = m_slice;

  axis_skid_slice #(
    .WIDTH (SLICE_WIDTH)
  ) u_skid (
    .clk     (axi_aclk),
    .rst     (axi_reset),
    .s_data  (s_slice),
    .s_valid (s_axis_tvalid),
    .s_ready (s_axis_tready),
    .m_data  (m_slice),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready)
  );

endmodule

`default_nettype wire

// File: tb/tb_rx_timestamp_tagger.sv
// ---------------------------------------------------------------------------
// tb_rx_timestamp_tagger: random + directed stimulus against a queue-based reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rx_timestamp_tagger;

  localparam int DW  = 256;
  localparam int SW  = DW / 8;
  localparam int UW  = 128;
  localparam int TW  = 64;
  localparam int OFF = 32;
`ifdef RX_TS_LATENCY_COMP_EN
  localparam int COMP = 8;
`else
  localparam int COMP = 0;
`endif

  logic          clk = 1'b0;
  logic          axi_reset;
  logic [TW-1:0] stamp_counter;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [31:0]   tagged_pkts;

  always #5 clk = ~clk;

  rx_timestamp_tagger #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .TIMESTAMP_WIDTH    (TW),
    .TS_TUSER_OFFSET    (OFF),
    .TS_COMP_TICKS      (COMP)
  ) dut (
    .axi_aclk      (clk),
    .axi_reset     (axi_reset),
    .stamp_counter (stamp_counter),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .tagged_pkts   (tagged_pkts)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic [UW-1:0] user;
    logic          last;
  } beat_t;

  // Reference model: a 2-deep in-order buffer whose ready reflects occupancy < 2.
  beat_t         q[$];
  bit            rdy_m;
  bit            in_pkt_m;
  bit            held_m;
  bit            hs_m;
  logic [TW-1:0] hold_m;
  int unsigned   cnt_m;
  int            errors = 0;
  int            checks = 0;
  int            beats_left = 0;

  function automatic logic [TW-1:0] arrival(input logic [TW-1:0] t);
`ifdef RX_TS_LATENCY_COMP_EN
    return t - TW'(COMP);
`else
    return t;
`endif
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_step();
    beat_t b;
    hs_m = 1'b0;
    if (axi_reset) begin
      q.delete();
      rdy_m    = 1'b0;
      in_pkt_m = 1'b0;
      held_m   = 1'b0;
      cnt_m    = 0;
      return;
    end
    hs_m = s_axis_tvalid && rdy_m;
    if (hs_m) begin
      b.data = s_axis_tdata;
      b.strb = s_axis_tstrb;
      b.user = s_axis_tuser;
      b.last = s_axis_tlast;
      if (!in_pkt_m) begin
        b.user[OFF +: TW] = held_m ? hold_m : arrival(stamp_counter);
        cnt_m++;
        held_m = 1'b0;
      end
      in_pkt_m = !s_axis_tlast;
    end else if (s_axis_tvalid && !in_pkt_m && !held_m) begin
      hold_m = arrival(stamp_counter);
      held_m = 1'b1;
    end
    if (q.size() > 0 && m_axis_tready) void'(q.pop_front());
    if (hs_m) q.push_back(b);
    rdy_m = (q.size() < 2);
  endtask

  task automatic compare();
    check("s_tready", 256'(s_axis_tready), 256'(rdy_m));
    check("m_tvalid", 256'(m_axis_tvalid), 256'(q.size() > 0));
    check("tagged_pkts", 256'(tagged_pkts), 256'(cnt_m));
    if (q.size() > 0) begin
      check("m_tdata", m_axis_tdata, q[0].data);
      check("m_tstrb", 256'(m_axis_tstrb), 256'(q[0].strb));
      check("m_tuser", 256'(m_axis_tuser), 256'(q[0].user));
      check("m_tlast", 256'(m_axis_tlast), 256'(q[0].last));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic load_beat();
    if (beats_left == 0) beats_left = $urandom_range(1, 4);
    for (int i = 0; i < DW / 32; i++) s_axis_tdata[i*32 +: 32] = $urandom;
    s_axis_tstrb = $urandom;
    for (int i = 0; i < UW / 32; i++) s_axis_tuser[i*32 +: 32] = $urandom;
    s_axis_tlast  = (beats_left == 1);
    beats_left--;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic drive_next(input int p_valid);
    if (hs_m || !s_axis_tvalid) begin
      if ($urandom_range(0, 99) < p_valid) load_beat();
      else s_axis_tvalid = 1'b0;
    end
  endtask

  initial begin
    int pv[4];
    int pr[4];
    logic [TW-1:0] exp_ts;
    pv = '{90, 70, 100, 50};
    pr = '{100, 50, 20, 80};

    axi_reset     = 1'b1;
    stamp_counter = '0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    tick();
    check("reset_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("reset_s_tready", 256'(s_axis_tready), 256'(0));
    check("reset_tagged", 256'(tagged_pkts), 256'(0));
    axi_reset = 1'b0;
    tick();

    // Single-beat packet, accepted on its first valid cycle.
`ifdef RX_TS_LATENCY_COMP_EN
    stamp_counter = 64'h5;
    exp_ts        = 64'hFFFF_FFFF_FFFF_FFFD;
`else
    stamp_counter = 64'h1000;
    exp_ts        = 64'h1000;
`endif
    beats_left = 1;
    load_beat();
    tick();
    check("lit_single_valid", 256'(m_axis_tvalid), 256'(1));
    check("lit_single_ts", 256'(m_axis_tuser[OFF +: TW]), 256'(exp_ts));
    check("lit_single_cnt", 256'(tagged_pkts), 256'(1));
    s_axis_tvalid = 1'b0;
    tick();

    // Reset during beat 2 of a 3-beat packet; beat 3 becomes a new stamped packet.
    beats_left = 3;
    load_beat();
    tick();
    load_beat();
    axi_reset = 1'b1;
    tick();
    check("lit_rst_m_tvalid", 256'(m_axis_tvalid), 256'(0));
    check("lit_rst_cnt", 256'(tagged_pkts), 256'(0));
    axi_reset     = 1'b0;
    load_beat();
    stamp_counter = 64'h500;
    tick();
    stamp_counter = 64'h501;
    tick();
    exp_ts = 64'h500 - 64'(COMP);
    check("lit_rst_valid", 256'(m_axis_tvalid), 256'(1));
    check("lit_rst_ts", 256'(m_axis_tuser[OFF +: TW]), 256'(exp_ts));
    check("lit_rst_cnt1", 256'(tagged_pkts), 256'(1));
    s_axis_tvalid = 1'b0;
    beats_left    = 0;
    tick();

    // Randomized phases: varying source density and sink backpressure, stamp jumps, resets.
    for (int ph = 0; ph < 4; ph++) begin
      for (int n = 0; n < 800; n++) begin
        m_axis_tready = ($urandom_range(0, 99) < pr[ph]);
        if ($urandom_range(0, 49) == 0) stamp_counter = {$urandom, $urandom};
        else stamp_counter = stamp_counter + 64'd1;
        axi_reset = ($urandom_range(0, 399) == 0);
        tick();
        axi_reset = 1'b0;
        drive_next(pv[ph]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
